// File: rtl/mic_sample_buffer.sv
// mic_sample_buffer: capture stage behind the Pmod MIC SPI front end.
// It generates the periodic read strobe and waits for new_data, with a
// timeout. Each captured sample is converted from offset binary to two's
// complement and queued in a first-word-fall-through FIFO. The FIFO drives
// a valid/ready stream. Sticky flags report overflow, timeout and late ticks.
// Optional feature: define MIC_PEAK_EN to track the peak absolute sample on
// the peak port. Without the macro, peak is constant 0.
module mic_sample_buffer #(
  parameter int unsigned SAMPLE_DIV = 2500,
  parameter int unsigned TIMEOUT    = 1023,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clr_flags,
  output logic                  read,
  input  logic [11:0]           audio,
  input  logic                  new_data,
  output logic [11:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  output logic                  tmo,
  output logic                  late,
  output logic [10:0]           peak
);

  localparam int unsigned SW    = 12;
  localparam int unsigned CW    = 16;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] TMO_LIM  = CW'(TIMEOUT);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_e;

  // ---------------------------------------------------------------------
  // Sample tick generation
  // ---------------------------------------------------------------------
  logic [CW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = enable && (tick_cnt_q == DIV_LAST);

  // Free-running divider; disabled means parked at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (!enable || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + CW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Conversion request FSM
  // ---------------------------------------------------------------------
  state_e        state_q;
  logic          read_q;
  logic [CW-1:0] tmo_cnt_q;
  logic          in_wait;
  logic          push;
  logic          tmo_evt;
  logic          late_evt;

  assign in_wait  = (state_q == ST_WAIT);
  assign push     = in_wait && new_data;
  assign tmo_evt  = in_wait && !new_data && (tmo_cnt_q == TMO_LIM);
  assign late_evt = tick && (state_q != ST_IDLE);

  // Tick starts a request. REQ emits the strobe, and WAIT ends on data or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      read_q    <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      read_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          read_q    <= 1'b1;
          tmo_cnt_q <= '0;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (new_data || (tmo_cnt_q == TMO_LIM)) begin
            state_q <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign read = read_q;

  // ---------------------------------------------------------------------
  // Offset binary to two's complement: flipping the MSB subtracts 2048
  // ---------------------------------------------------------------------
  logic [SW-1:0] sample;

  assign sample = {~audio[SW-1], audio[SW-2:0]};

  // ---------------------------------------------------------------------
  // FWFT FIFO with a registered head
  // ---------------------------------------------------------------------
  logic [SW-1:0]         mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_d;
  logic [LW-1:0]         count_q;
  logic [LW-1:0]         count_d;
  logic [SW-1:0]         head_q;
  logic [SW-1:0]         head_d;
  logic                  valid_q;
  logic                  full;
  logic                  pop;
  logic                  push_ok;
  logic                  ovf_evt;

  assign full    = (count_q == FULL_LVL);
  assign pop     = valid_q && out_ready;
  assign push_ok = push && (!full || pop);
  assign ovf_evt = push && full && !pop;

  // Next occupancy, read pointer and head word.
  // The head bypasses the array when the write lands in the next read slot.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end
    if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
      head_d = sample;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Sample storage (contents need no reset, validity is tracked by count_q).
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= sample;
    end
  end

  // Pointers, occupancy and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
    end
  end

  assign out_data  = head_q;
  assign out_valid = valid_q;
  assign level     = count_q;

  // ---------------------------------------------------------------------
  // Sticky status flags
  // ---------------------------------------------------------------------
  logic ovf_q;
  logic tmo_q;
  logic late_q;

  // A set event in the same cycle as clr_flags wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      tmo_q  <= 1'b0;
      late_q <= 1'b0;
    end else begin
      ovf_q  <= (ovf_q  & ~clr_flags) | ovf_evt;
      tmo_q  <= (tmo_q  & ~clr_flags) | tmo_evt;
      late_q <= (late_q & ~clr_flags) | late_evt;
    end
  end

  assign ovf  = ovf_q;
  assign tmo  = tmo_q;
  assign late = late_q;

  // ---------------------------------------------------------------------
  // Peak absolute value
  // ---------------------------------------------------------------------
`ifdef MIC_PEAK_EN
  logic [10:0] mag;
  logic [10:0] peak_q;
  logic [10:0] peak_base;

  // |sample|, with -2048 saturated to 2047.
  // The base is zero when a clear arrives with a push.
  always_comb begin
    if (sample[SW-1]) begin
      if (sample[SW-2:0] == '0) begin
        mag = 11'h7FF;
      end else begin
        mag = ~sample[SW-2:0] + 11'd1;
      end
    end else begin
      mag = sample[SW-2:0];
    end
    peak_base = clr_flags ? '0 : peak_q;
  end

  // Running maximum over accepted samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
    end else if (push_ok && (mag > peak_base)) begin
      peak_q <= mag;
    end else begin
      peak_q <= peak_base;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_mic_sample_buffer.sv
// Directed self-checking bench for mic_sample_buffer.
// The main instance uses SAMPLE_DIV=200 and TIMEOUT=50.
// A second instance uses TIMEOUT=1023, so a conversion can outlast a tick.
module tb_mic_sample_buffer;

  localparam int unsigned DL2 = 4;

  logic           clk;
  logic           rst;
  logic           clr_flags;

  logic           enable;
  logic           read;
  logic [11:0]    audio;
  logic           new_data;
  logic [11:0]    out_data;
  logic           out_valid;
  logic           out_ready;
  logic [DL2:0]   level;
  logic           ovf;
  logic           tmo;
  logic           late;
  logic [10:0]    peak;

  logic           l_enable;
  logic           l_read;
  logic [11:0]    l_audio;
  logic           l_new_data;
  logic [11:0]    l_out_data;
  logic           l_out_valid;
  logic           l_out_ready;
  logic [DL2:0]   l_level;
  logic           l_ovf;
  logic           l_tmo;
  logic           l_late;
  logic [10:0]    l_peak;

  int n_checks = 0;
  int n_fail   = 0;

  mic_sample_buffer #(.SAMPLE_DIV(200), .TIMEOUT(50), .DEPTH_LOG2(DL2)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_flags(clr_flags),
    .read(read), .audio(audio), .new_data(new_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .ovf(ovf), .tmo(tmo), .late(late), .peak(peak)
  );

  mic_sample_buffer #(.SAMPLE_DIV(200), .TIMEOUT(1023), .DEPTH_LOG2(DL2)) u_dut_late (
    .clk(clk), .rst(rst), .enable(l_enable), .clr_flags(clr_flags),
    .read(l_read), .audio(l_audio), .new_data(l_new_data),
    .out_data(l_out_data), .out_valid(l_out_valid), .out_ready(l_out_ready),
    .level(l_level), .ovf(l_ovf), .tmo(l_tmo), .late(l_late), .peak(l_peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait, with a bound, for a read strobe on the selected instance.
  task automatic wait_read(input bit sel, output int n);
    n = 0;
    while (((sel ? l_read : read) !== 1'b1) && (n < 400)) begin
      step();
      n++;
    end
    if (n >= 400) chk("read_wait_expired", 32'(n), 32'd0);
  endtask

  // Model the front end: deliver a conversion d cycles after the strobe.
  task automatic send(input logic [11:0] a, input int d);
    repeat (d) step();
    audio    = a;
    new_data = 1'b1;
    step();
    new_data = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
  endtask

  function automatic logic [11:0] conv(input logic [11:0] a);
    return a - 12'd2048;
  endfunction

  function automatic logic [11:0] ov(input int k);
    return 12'(k * 211 + 37);
  endfunction

  function automatic logic [31:0] pk(input int v);
`ifdef MIC_PEAK_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  int conv_in [6] = '{2048, 100, 3500, 0, 4095, 3000};
  int peak_ex [6] = '{0, 1948, 1948, 2047, 2047, 2047};

  initial begin
    int n;
    rst = 1'b1; clr_flags = 1'b0;
    enable = 1'b0; audio = '0; new_data = 1'b0; out_ready = 1'b0;
    l_enable = 1'b0; l_audio = '0; l_new_data = 1'b0; l_out_ready = 1'b0;
    repeat (3) step();

    chk("rst_read", 32'(read), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    chk("rst_late", 32'(late), 32'd0);
    chk("rst_peak", 32'(peak), 32'd0);

    rst = 1'b0;
    step();
    enable = 1'b1;

    // First strobe: 200 divider cycles, then IDLE->REQ, then read.
    wait_read(1'b0, n);
    chk("first_read_delay", 32'(n), 32'd201);
    step();
    chk("read_width", 32'(read), 32'd0);

    // Withhold new_data: tmo appears 51 cycles after read.
    repeat (49) step();
    chk("tmo_before_limit", 32'(tmo), 32'd0);
    step();
    chk("tmo_set", 32'(tmo), 32'd1);
    chk("tmo_no_push", 32'(level), 32'd0);
    chk("tmo_no_valid", 32'(out_valid), 32'd0);

    wait_read(1'b0, n);
    chk("read_spacing", 32'(n + 51), 32'd200);

    // Conversions accumulate with out_ready low, and the head stays stable.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) wait_read(1'b0, n);
      send(12'(conv_in[i]), i);
      chk("conv_level", 32'(level), 32'(i + 1));
      chk("conv_head", 32'(out_data), 32'(conv(12'(conv_in[0]))));
      chk("conv_valid", 32'(out_valid), 32'd1);
      chk("peak_track", 32'(peak), pk(peak_ex[i]));
      if (i == 2) begin
        chk("tmo_sticky", 32'(tmo), 32'd1);
        pulse_clr();
        chk("tmo_cleared", 32'(tmo), 32'd0);
        chk("peak_cleared", 32'(peak), 32'd0);
      end
    end

    // Drain in push order.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("pop_order", 32'(out_data), 32'(conv(12'(conv_in[i]))));
      chk("pop_valid", 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b0;
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drained_level", 32'(level), 32'd0);

    // new_data while IDLE is ignored.
    audio = 12'd1234; new_data = 1'b1;
    step();
    new_data = 1'b0;
    step();
    chk("stray_level", 32'(level), 32'd0);
    chk("stray_valid", 32'(out_valid), 32'd0);

    // Overflow: 17 conversions into a 16-deep FIFO.
    for (int k = 0; k < 17; k++) begin
      wait_read(1'b0, n);
      send(ov(k), 0);
      if (k == 15) begin
        chk("full_level", 32'(level), 32'd16);
        chk("full_no_ovf", 32'(ovf), 32'd0);
      end
    end
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_head", 32'(out_data), 32'(conv(ov(0))));
    pulse_clr();
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Push and pop together while full.
    wait_read(1'b0, n);
    audio = 12'hABC; new_data = 1'b1; out_ready = 1'b1;
    step();
    new_data = 1'b0; out_ready = 1'b0;
    chk("pp_level", 32'(level), 32'd16);
    chk("pp_no_ovf", 32'(ovf), 32'd0);
    chk("pp_head", 32'(out_data), 32'(conv(ov(1))));

    out_ready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      chk("pp_drain", 32'(out_data), 32'(conv(ov(k))));
      step();
    end
    chk("pp_tail", 32'(out_data), 32'(conv(12'hABC)));
    step();
    out_ready = 1'b0;
    chk("pp_empty", 32'(out_valid), 32'd0);

    // Reset during a conversion, with one entry queued.
    wait_read(1'b0, n);
    send(12'h123, 0);
    chk("pre_rst_level", 32'(level), 32'd1);
    wait_read(1'b0, n);
    rst = 1'b1;
    #1;
    chk("midrst_read", 32'(read), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0;
    audio = 12'h456; new_data = 1'b1;
    step();
    new_data = 1'b0;
    chk("post_rst_ignored", 32'(level), 32'd0);
    chk("post_rst_read", 32'(read), 32'd0);

    // A slow conversion spans a tick: late is set, and the tick is not queued.
    l_enable = 1'b1;
    wait_read(1'b1, n);
    chk("late_first_read", 32'(n), 32'd201);
    for (int k = 1; k <= 250; k++) begin
      step();
      if (k == 190) chk("late_before_tick", 32'(l_late), 32'd0);
    end
    chk("late_set", 32'(l_late), 32'd1);
    l_audio = 12'd3000; l_new_data = 1'b1;
    step();
    l_new_data = 1'b0;
    chk("late_push_level", 32'(l_level), 32'd1);
    chk("late_push_data", 32'(l_out_data), 32'd952);
    pulse_clr();
    chk("late_cleared", 32'(l_late), 32'd0);
    wait_read(1'b1, n);
    chk("late_tick_dropped", 32'(n), 32'd148);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
